axi_ram_slave: RTL and testbench

Single-port AXI3 slave memory that consumes the CPU core's AXI master channels (AR/R/AW/W/B) in simulation and FPGA bring-up. It is the block directly downstream of the core's AXI bridge. It serves one outstanding read and one outstanding write concurrently, each with its own fixed programmable latency, so the core's handshake logic can be exercised under stall. Only single-beat transfers are served; burst requests get an error response.

---
 rtl/axi_ram_slave.sv | 264 ++++++++++++++++++++++++++
 tb/tb_axi_ram_slave.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_ram_slave.sv
// axi_ram_slave: single-beat AXI3 slave RAM with independent read and write
// engines, each returning its response after a fixed programmable latency.
module axi_ram_slave #(
    parameter int unsigned MEM_AW     = 16,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned WR_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  arid,
    input  logic [31:0] araddr,
    input  logic [7:0]  arlen,
    input  logic [2:0]  arsize,
    input  logic [1:0]  arburst,
    input  logic        arvalid,
    output logic        arready,
    output logic [3:0]  rid,
    output logic [31:0] rdata,
    output logic [1:0]  rresp,
    output logic        rlast,
    output logic        rvalid,
    input  logic        rready,
    input  logic [3:0]  awid,
    input  logic [31:0] awaddr,
    input  logic [7:0]  awlen,
    input  logic [2:0]  awsize,
    input  logic [1:0]  awburst,
    input  logic        awvalid,
    output logic        awready,
    input  logic [3:0]  wid,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    input  logic        wlast,
    input  logic        wvalid,
    output logic        wready,
    output logic [3:0]  bid,
    output logic [1:0]  bresp,
    output logic        bvalid,
    input  logic        bready
);

    localparam int unsigned CNT_W = 4;
    localparam int unsigned DEPTH = 1 << MEM_AW;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
    typedef enum logic [2:0] {W_IDLE, W_GOT_A, W_GOT_D, W_WAIT, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    r_state_t          r_state_q, r_state_d;
    logic [CNT_W-1:0]  r_cnt_q, r_cnt_d;
    logic [MEM_AW-1:0] r_idx_q, r_idx_d;
    logic              r_err_q, r_err_d;
    logic [3:0]        rid_q, rid_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic              arready_q, arready_d;

    w_state_t          w_state_q, w_state_d;
    logic [CNT_W-1:0]  w_cnt_q, w_cnt_d;
    logic [MEM_AW-1:0] w_idx_q, w_idx_d;
    logic              w_err_q, w_err_d;
    logic [31:0]       w_data_q, w_data_d;
    logic [3:0]        w_strb_q, w_strb_d;
    logic [3:0]        bid_q, bid_d;
    logic [1:0]        bresp_q, bresp_d;
    logic              bvalid_q, bvalid_d;
    logic              awready_q, awready_d;
    logic              wready_q, wready_d;

    logic              commit_c;
    logic              mem_we_c;
    logic [MEM_AW-1:0] c_idx_c;
    logic [31:0]       c_data_c;
    logic [3:0]        c_strb_c;
    logic              c_err_c;
    logic              unused_c;

    // Read engine: accept AR, count down the latency, sample the array, hold R until taken.
    always_comb begin
        r_state_d = r_state_q;
        r_cnt_d   = r_cnt_q;
        r_idx_d   = r_idx_q;
        r_err_d   = r_err_q;
        rid_d     = rid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        case (r_state_q)
            R_IDLE: begin
                if (arvalid) begin
                    rid_d     = arid;
                    r_idx_d   = araddr[MEM_AW+1:2];
                    r_err_d   = (arlen != 8'd0);
                    r_cnt_d   = CNT_W'(RD_LATENCY - 1);
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (r_cnt_q == '0) begin
                    rdata_d   = r_err_q ? 32'd0 : mem[r_idx_q];
                    rresp_d   = r_err_q ? RESP_SLVERR : RESP_OKAY;
                    r_state_d = R_RESP;
                end else begin
                    r_cnt_d = r_cnt_q - CNT_W'(1);
                end
            end
            R_RESP: begin
                if (rready) r_state_d = R_IDLE;
            end
            default: r_state_d = R_IDLE;
        endcase
        arready_d = (r_state_d == R_IDLE);
        rvalid_d  = (r_state_d == R_RESP);
        rlast_d   = rvalid_d;
    end

    // Write engine: gather AW and W in either order, commit on the second handshake.
    always_comb begin
        w_state_d = w_state_q;
        w_cnt_d   = w_cnt_q;
        w_idx_d   = w_idx_q;
        w_err_d   = w_err_q;
        w_data_d  = w_data_q;
        w_strb_d  = w_strb_q;
        bid_d     = bid_q;
        bresp_d   = bresp_q;
        commit_c  = 1'b0;
        c_idx_c   = w_idx_q;
        c_data_c  = w_data_q;
        c_strb_c  = w_strb_q;
        c_err_c   = w_err_q;
        case (w_state_q)
            W_IDLE: begin
                if (awvalid && wvalid) begin
                    commit_c = 1'b1;
                    c_idx_c  = awaddr[MEM_AW+1:2];
                    c_err_c  = (awlen != 8'd0);
                    c_data_c = wdata;
                    c_strb_c = wstrb;
                    bid_d    = awid;
                end else if (awvalid) begin
                    w_idx_d   = awaddr[MEM_AW+1:2];
                    w_err_d   = (awlen != 8'd0);
                    bid_d     = awid;
                    w_state_d = W_GOT_A;
                end else if (wvalid) begin
                    w_data_d  = wdata;
                    w_strb_d  = wstrb;
                    w_state_d = W_GOT_D;
                end
            end
            W_GOT_A: begin
                if (wvalid) begin
                    commit_c = 1'b1;
                    c_data_c = wdata;
                    c_strb_c = wstrb;
                end
            end
            W_GOT_D: begin
                if (awvalid) begin
                    commit_c = 1'b1;
                    c_idx_c  = awaddr[MEM_AW+1:2];
                    c_err_c  = (awlen != 8'd0);
                    bid_d    = awid;
                end
            end
            W_WAIT: begin
                if (w_cnt_q == '0) w_state_d = W_RESP;
                else               w_cnt_d   = w_cnt_q - CNT_W'(1);
            end
            W_RESP: begin
                if (bready) w_state_d = W_IDLE;
            end
            default: w_state_d = W_IDLE;
        endcase
        if (commit_c) begin
            bresp_d   = c_err_c ? RESP_SLVERR : RESP_OKAY;
            w_cnt_d   = CNT_W'(WR_LATENCY - 1);
            w_state_d = W_WAIT;
        end
        mem_we_c  = commit_c && !c_err_c && !rst;
        awready_d = (w_state_d == W_IDLE) || (w_state_d == W_GOT_D);
        wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_GOT_A);
        bvalid_d  = (w_state_d == W_RESP);
    end

    // Array write with byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_c) begin
            for (int i = 0; i < 4; i++) begin
                if (c_strb_c[i]) mem[c_idx_c][8*i +: 8] <= c_data_c[8*i +: 8];
            end
        end
    end

    // State and registered outputs for both engines.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= R_IDLE;
            r_cnt_q   <= '0;
            r_idx_q   <= '0;
            r_err_q   <= 1'b0;
            rid_q     <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            arready_q <= 1'b1;
            w_state_q <= W_IDLE;
            w_cnt_q   <= '0;
            w_idx_q   <= '0;
            w_err_q   <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bid_q     <= '0;
            bresp_q   <= RESP_OKAY;
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
        end else begin
            r_state_q <= r_state_d;
            r_cnt_q   <= r_cnt_d;
            r_idx_q   <= r_idx_d;
            r_err_q   <= r_err_d;
            rid_q     <= rid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            arready_q <= arready_d;
            w_state_q <= w_state_d;
            w_cnt_q   <= w_cnt_d;
            w_idx_q   <= w_idx_d;
            w_err_q   <= w_err_d;
            w_data_q  <= w_data_d;
            w_strb_q  <= w_strb_d;
            bid_q     <= bid_d;
            bresp_q   <= bresp_d;
            bvalid_q  <= bvalid_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
        end
    end

    assign arready = arready_q;
    assign rid     = rid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;
    assign rlast   = rlast_q;
    assign rvalid  = rvalid_q;
    assign awready = awready_q;
    assign wready  = wready_q;
    assign bid     = bid_q;
    assign bresp   = bresp_q;
    assign bvalid  = bvalid_q;

    // Attribute inputs and address bits this slave does not decode.
    assign unused_c = ^{arsize, arburst, awsize, awburst, wid, wlast, araddr, awaddr};

endmodule

// File: tb/tb_axi_ram_slave.sv
// tb_axi_ram_slave: scoreboard bench for axi_ram_slave with a small word model.
module tb_axi_ram_slave;

    localparam int unsigned MEM_AW = 4;
    localparam int unsigned RD_LAT = 2;
    localparam int unsigned WR_LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    always #5 clk = ~clk;

    axi_ram_slave #(.MEM_AW(MEM_AW), .RD_LATENCY(RD_LAT), .WR_LATENCY(WR_LAT)) dut (
        .clk(clk), .rst(rst),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
    } rexp_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } bexp_t;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] model [16];
    rexp_t rq[$];
    bexp_t bq[$];

    // Count one comparison and report it when it differs.
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) & 32'hF);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one AR; returns just after the handshake edge.
    task automatic read_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        rexp_t e;
        int n;
        n = 0;
        e.id   = id;
        e.resp = (len != 8'd0) ? 2'b10 : 2'b00;
        e.data = (len != 8'd0) ? 32'd0 : model[widx(addr)];
        rq.push_back(e);
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        while (arready !== 1'b1 && n < 50) begin tick(); n++; end
        if (n >= 50) check_eq("ar_timeout", 32'(n), 32'd0);
        tick();
        arvalid = 1'b0;
        check_eq("arready_busy", 32'(arready), 32'd0);
    endtask

    // Wait for R, optionally hold rready low, then pop and compare.
    task automatic read_resp(input int stall);
        rexp_t e;
        int lat;
        logic [31:0] d0;
        logic [3:0]  i0;
        lat = 0;
        while (rvalid !== 1'b1 && lat < 50) begin tick(); lat++; end
        check_eq("r_latency", 32'(lat), 32'(RD_LAT));
        d0 = rdata;
        i0 = rid;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("r_hold_valid", 32'(rvalid), 32'd1);
            check_eq("r_hold_data", rdata, d0);
            check_eq("r_hold_id", 32'(rid), 32'(i0));
            check_eq("r_hold_arready", 32'(arready), 32'd0);
        end
        check_eq("rq_size", 32'(rq.size()), 32'd1);
        if (rq.size() > 0) begin
            e = rq.pop_front();
            check_eq("rid", 32'(rid), 32'(e.id));
            check_eq("rdata", rdata, e.data);
            check_eq("rresp", 32'(rresp), 32'(e.resp));
            check_eq("rlast", 32'(rlast), 32'd1);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check_eq("r_done_valid", 32'(rvalid), 32'd0);
        check_eq("r_done_arready", 32'(arready), 32'd1);
    endtask

    // Drive AW/W (mode 0 together, 1 W first, 2 AW first); returns after commit edge.
    task automatic write_req(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [7:0] len, input int mode);
        bexp_t e;
        int n;
        n = 0;
        while (!(awready === 1'b1 && wready === 1'b1) && n < 50) begin tick(); n++; end
        if (n >= 50) check_eq("w_idle_timeout", 32'(n), 32'd0);
        awid = id; awaddr = addr; awlen = len; wdata = data; wstrb = strb;
        case (mode)
            1: begin
                wvalid = 1'b1;
                tick();
                wvalid = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    check_eq("wfirst_wready", 32'(wready), 32'd0);
                    check_eq("wfirst_awready", 32'(awready), 32'd1);
                    if (i < 2) tick();
                end
                awvalid = 1'b1;
                tick();
                awvalid = 1'b0;
            end
            2: begin
                awvalid = 1'b1;
                tick();
                awvalid = 1'b0;
                for (int i = 0; i < 3; i++) begin
                    check_eq("afirst_awready", 32'(awready), 32'd0);
                    check_eq("afirst_wready", 32'(wready), 32'd1);
                    if (i < 2) tick();
                end
                wvalid = 1'b1;
                tick();
                wvalid = 1'b0;
            end
            default: begin
                awvalid = 1'b1;
                wvalid  = 1'b1;
                tick();
                awvalid = 1'b0;
                wvalid  = 1'b0;
            end
        endcase
        check_eq("w_busy_awready", 32'(awready), 32'd0);
        check_eq("w_busy_wready", 32'(wready), 32'd0);
        e.id   = id;
        e.resp = (len != 8'd0) ? 2'b10 : 2'b00;
        bq.push_back(e);
        if (len == 8'd0) begin
            for (int i = 0; i < 4; i++) begin
                if (strb[i]) model[widx(addr)][8*i +: 8] = data[8*i +: 8];
            end
        end
    endtask

    // Wait for B, optionally hold bready low, then pop and compare.
    task automatic write_resp(input int stall);
        bexp_t e;
        int lat;
        logic [3:0] i0;
        lat = 0;
        while (bvalid !== 1'b1 && lat < 50) begin tick(); lat++; end
        check_eq("b_latency", 32'(lat), 32'(WR_LAT));
        i0 = bid;
        for (int i = 0; i < stall; i++) begin
            tick();
            check_eq("b_hold_valid", 32'(bvalid), 32'd1);
            check_eq("b_hold_id", 32'(bid), 32'(i0));
        end
        check_eq("bq_size", 32'(bq.size()), 32'd1);
        if (bq.size() > 0) begin
            e = bq.pop_front();
            check_eq("bid", 32'(bid), 32'(e.id));
            check_eq("bresp", 32'(bresp), 32'(e.resp));
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check_eq("b_done_valid", 32'(bvalid), 32'd0);
        check_eq("b_done_awready", 32'(awready), 32'd1);
        check_eq("b_done_wready", 32'(wready), 32'd1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_arready"}, 32'(arready), 32'd1);
        check_eq({tag, "_awready"}, 32'(awready), 32'd1);
        check_eq({tag, "_wready"}, 32'(wready), 32'd1);
        check_eq({tag, "_rvalid"}, 32'(rvalid), 32'd0);
        check_eq({tag, "_bvalid"}, 32'(bvalid), 32'd0);
        check_eq({tag, "_rlast"}, 32'(rlast), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = 2'd1; arvalid = 1'b0;
        rready = 1'b0;
        awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = 2'd1; awvalid = 1'b0;
        wid = '0; wdata = '0; wstrb = '0; wlast = 1'b1; wvalid = 1'b0;
        bready = 1'b0;

        // Reset values, before any clock edge.
        #1 rst = 1'b1;
        #1;
        check_idle_outputs("rst");
        check_eq("rst_rid", 32'(rid), 32'd0);
        check_eq("rst_bid", 32'(bid), 32'd0);
        check_eq("rst_rdata", rdata, 32'd0);
        check_eq("rst_rresp", 32'(rresp), 32'd0);
        check_eq("rst_bresp", 32'(bresp), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        tick();

        // Full write then read.
        write_req(4'd5, 32'h10, 32'hDEADBEEF, 4'hF, 8'd0, 0);
        write_resp(0);
        read_req(4'd3, 32'h10, 8'd0);
        read_resp(0);

        // Partial strobe merge.
        write_req(4'd1, 32'h20, 32'h11223344, 4'hF, 8'd0, 0);
        write_resp(0);
        write_req(4'd2, 32'h20, 32'hAABBCCDD, 4'b0101, 8'd0, 0);
        write_resp(0);
        read_req(4'd4, 32'h20, 8'd0);
        read_resp(0);

        // W before AW, then AW before W with B backpressure.
        write_req(4'd6, 32'h30, 32'h0BADF00D, 4'hF, 8'd0, 1);
        write_resp(0);
        write_req(4'd7, 32'h34, 32'hCAFE1234, 4'hF, 8'd0, 2);
        write_resp(3);

        // R backpressure, then back-to-back read.
        read_req(4'd9, 32'h30, 8'd0);
        read_resp(5);
        read_req(4'd10, 32'h34, 8'd0);
        read_resp(0);

        // Burst requests get SLVERR; a burst write leaves the array untouched.
        read_req(4'd11, 32'h10, 8'd3);
        read_resp(0);
        write_req(4'd12, 32'h10, 32'h12345678, 4'hF, 8'd1, 0);
        write_resp(0);
        read_req(4'd13, 32'h10, 8'd0);
        read_resp(0);

        // Address wrap: 0x40 aliases 0x00 with 16 words.
        write_req(4'd14, 32'h40, 32'h5A5A1234, 4'hF, 8'd0, 0);
        write_resp(0);
        read_req(4'd15, 32'h00, 8'd0);
        read_resp(0);

        // Reset with a write in W_RESP and a read in R_WAIT.
        write_req(4'd8, 32'h08, 32'h76543210, 4'hF, 8'd0, 0);
        n = 0;
        while (bvalid !== 1'b1 && n < 50) begin tick(); n++; end
        check_eq("pre_rst_bvalid", 32'(bvalid), 32'd1);
        read_req(4'd1, 32'h08, 8'd0);
        #2 rst = 1'b1;
        #1;
        check_idle_outputs("async_rst");
        rq.delete();
        bq.delete();
        @(negedge clk);
        rst = 1'b0;
        tick();
        read_req(4'd2, 32'h08, 8'd0);
        read_resp(0);
        read_req(4'd3, 32'h10, 8'd0);
        read_resp(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
